// File: rtl/epd_defs_pkg.sv
// epd_defs_pkg: framing constants and state encoding shared by the packet generator and detector.
package epd_defs_pkg;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam int PREAMBLE_LEN = 7;
  localparam int ADDR_LEN = 6;
  localparam int TYPE_LEN = 2;
  localparam int MIN_PAYLOAD_DEF = 46;
  localparam int MAX_PAYLOAD_DEF = 1500;
  localparam int IFG_CYCLES_DEF = 12;
  typedef enum logic [3:0] {
    ST_IDLE, ST_PRE, ST_SFD, ST_DST, ST_SRC, ST_TYPE, ST_PAY, ST_PAD, ST_IFG
  } state_e;
endpackage

// File: rtl/epd_hdr_sel.sv
// epd_hdr_sel: picks header byte idx (0..13 over dst, src, type) from the latched fields.
module epd_hdr_sel (
  input  logic [47:0] dst_i,
  input  logic [47:0] src_i,
  input  logic [15:0] type_i,
  input  logic [3:0]  idx_i,
  output logic [7:0]  byte_o
);
  logic [111:0] hdr;
  assign hdr = {dst_i, src_i, type_i};
  assign byte_o = hdr[{4'd13 - idx_i, 3'b000} +: 8];
endmodule

// File: rtl/epd_tx_gen.sv
// epd_tx_gen: serialises one Ethernet frame per request onto a data/control byte stream.
module epd_tx_gen
  import epd_defs_pkg::*;
#(
  parameter int IFG_CYCLES  = IFG_CYCLES_DEF,
  parameter int MIN_PAYLOAD = MIN_PAYLOAD_DEF,
  parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [47:0] dst_addr,
  input  logic [47:0] src_addr,
  input  logic [15:0] type_length,
  input  logic [10:0] payload_len,
  input  logic [7:0]  payload_data,
  input  logic        payload_valid,
  output logic        payload_ready,
  output logic [7:0]  data,
  output logic        control,
  output logic        busy,
  output logic        frame_done,
  output logic        err_len,
  output logic        err_underrun,
  output logic [3:0]  frames_sent
);
  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d, len_q;
  logic [47:0] dst_q, src_q;
  logic [15:0] type_q;
  logic [7:0]  data_d, hdr_byte;
  logic [3:0]  hdr_idx;
  logic        control_d, done_d, err_len_d, err_un_d;
  logic        accept, legal, pay_last, short_pay;
  assign legal = payload_len != 11'd0 && payload_len <= 11'(MAX_PAYLOAD);
  assign accept = state_q == ST_IDLE && start;
  assign pay_last = cnt_q == len_q - 11'd1;
  assign short_pay = len_q < 11'(MIN_PAYLOAD);
  assign busy = state_q != ST_IDLE;
  // Ready runs one cycle ahead of the byte it fetches.
  assign payload_ready = (state_q == ST_TYPE && cnt_q == 11'(TYPE_LEN - 1)) ||
                         (state_q == ST_PAY && !pay_last);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 11'd1;
    done_d = 1'b0;
    err_len_d = 1'b0;
    err_un_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        state_d = accept && legal ? ST_PRE : ST_IDLE;
        err_len_d = accept && !legal;
      end
      ST_PRE: if (cnt_q == 11'(PREAMBLE_LEN - 1)) begin
        state_d = ST_SFD;
        cnt_d = '0;
      end
      ST_SFD: begin
        state_d = ST_DST;
        cnt_d = '0;
      end
      ST_DST: if (cnt_q == 11'(ADDR_LEN - 1)) begin
        state_d = ST_SRC;
        cnt_d = '0;
      end
      ST_SRC: if (cnt_q == 11'(ADDR_LEN - 1)) begin
        state_d = ST_TYPE;
        cnt_d = '0;
      end
      ST_TYPE: if (cnt_q == 11'(TYPE_LEN - 1)) begin
        state_d = ST_PAY;
        cnt_d = '0;
      end
      // Pad keeps counting from the payload index up to MIN_PAYLOAD-1.
      ST_PAY: if (pay_last) begin
        state_d = short_pay ? ST_PAD : ST_IFG;
        cnt_d = short_pay ? cnt_q + 11'd1 : '0;
        done_d = !short_pay;
      end
      ST_PAD: if (cnt_q == 11'(MIN_PAYLOAD - 1)) begin
        state_d = ST_IFG;
        cnt_d = '0;
        done_d = 1'b1;
      end
      ST_IFG: if (cnt_q == 11'(IFG_CYCLES - 1)) begin
        state_d = ST_IDLE;
        cnt_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d = '0;
      end
    endcase
    if (payload_ready && !payload_valid) begin
      state_d = ST_IFG;
      cnt_d = '0;
      err_un_d = 1'b1;
    end
  end
  always_comb begin
    hdr_idx = state_d == ST_DST ? cnt_d[3:0] :
              state_d == ST_SRC ? 4'(ADDR_LEN) + cnt_d[3:0] : 4'(2 * ADDR_LEN) + cnt_d[3:0];
    control_d = state_d inside {ST_PRE, ST_SFD, ST_DST, ST_SRC, ST_TYPE, ST_PAY, ST_PAD};
    data_d = state_d == ST_PRE ? PREAMBLE_BYTE :
             state_d == ST_SFD ? SFD_BYTE :
             state_d inside {ST_DST, ST_SRC, ST_TYPE} ? hdr_byte :
             state_d == ST_PAY ? payload_data : 8'h00;
  end
  epd_hdr_sel u_hdr_sel (
    .dst_i  (dst_q),
    .src_i  (src_q),
    .type_i (type_q),
    .idx_i  (hdr_idx),
    .byte_o (hdr_byte)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      len_q <= '0;
      dst_q <= '0;
      src_q <= '0;
      type_q <= '0;
      data <= '0;
      control <= 1'b0;
      frame_done <= 1'b0;
      err_len <= 1'b0;
      err_underrun <= 1'b0;
      frames_sent <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data <= data_d;
      control <= control_d;
      frame_done <= done_d;
      err_len <= err_len_d;
      err_underrun <= err_un_d;
      frames_sent <= frames_sent + {3'b000, done_d};
      if (accept) begin
        len_q <= payload_len;
        dst_q <= dst_addr;
        src_q <= src_addr;
        type_q <= type_length;
      end
    end
  end
endmodule
